// File: rtl/gpu_mem_pkg.sv
// Shared defaults and response record for the multi-port memory responder.
// Also holds the index-width helper used by the arbiter and the top.
package gpu_mem_pkg;

  localparam int PORTS_DEF      = 8;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 512;
  localparam int DEPTH_DEF      = 1024;

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH_DEF-1:0] data;
    logic                      err;
  } resp_t;

  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr.
// ptr moves to the slot after the winner on every grant.
module rr_arbiter
  import gpu_mem_pkg::*;
#(
  parameter  int PORTS = PORTS_DEF,
  localparam int PW    = idx_width(PORTS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [PORTS-1:0] req,
  output logic [PORTS-1:0] grant,
  output logic [PW-1:0]    grant_idx,
  output logic             any,
  output logic [PW-1:0]    ptr
);

  logic found;
  int   j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int i = 0; i < PORTS; i++) begin
      j = (int'(ptr) + i) % PORTS;
      if (!found && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = PW'(j);
        found     = 1'b1;
      end
    end
  end

  assign any = found;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (found) begin
      if (grant_idx == PW'(PORTS - 1))
        ptr <= '0;
      else
        ptr <= grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Multi-port word memory: one request accepted per cycle by round robin,
// response (data or write ack, plus range error) one cycle later.
module mem_responder
  import gpu_mem_pkg::*;
#(
  parameter int PORTS      = PORTS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [PORTS-1:0]      req_valid,
  input  logic [PORTS-1:0]      req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr [PORTS],
  input  logic [DATA_WIDTH-1:0] req_wdata [PORTS],
  output logic [PORTS-1:0]      req_ready,
  output logic [PORTS-1:0]      resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data [PORTS],
  output logic [PORTS-1:0]      resp_err
);

  localparam int PW = idx_width(PORTS);
  localparam int IW = idx_width(DEPTH);

  logic [PORTS-1:0]      req_live;
  logic [PORTS-1:0]      grant;
  logic [PW-1:0]         grant_idx;
  logic [PW-1:0]         rr_ptr;
  logic                  acc;

  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  in_range;
  logic [IW-1:0]         idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  pend_valid;
  logic [PW-1:0]         pend_port;
  logic                  pend_read;
  logic                  pend_err;

  logic [PORTS-1:0]      hit;
  resp_t                 resp [PORTS];

  // Masking with reset keeps every ready low while reset is held.
  assign req_live = req_valid & {PORTS{reset_n}};

  rr_arbiter #(
    .PORTS (PORTS)
  ) u_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req_live),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (acc),
    .ptr       (rr_ptr)
  );

  assign req_ready = grant;

  assign sel_write = req_write[grant_idx];
  assign sel_addr  = req_addr[grant_idx];
  assign sel_wdata = req_wdata[grant_idx];
  assign in_range  = 64'(sel_addr) < 64'(DEPTH);
  assign idx       = sel_addr[IW-1:0];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (acc && in_range && sel_write)
      mem[idx] <= sel_wdata;
    if (acc && in_range && !sel_write)
      rd_word <= mem[idx];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_port  <= '0;
      pend_read  <= 1'b0;
      pend_err   <= 1'b0;
    end else begin
      pend_valid <= acc;
      pend_port  <= grant_idx;
      pend_read  <= !sel_write;
      pend_err   <= !in_range;
    end
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      hit[p]       = pend_valid && (pend_port == PW'(p));
      resp[p]      = '0;
      resp[p].valid = hit[p];
      resp[p].err  = hit[p] && pend_err;
      if (hit[p] && pend_read && !pend_err)
        resp[p].data = DATA_WIDTH_DEF'(rd_word);
    end
  end

  always_comb begin
    resp_valid = '0;
    resp_err   = '0;
    for (int p = 0; p < PORTS; p++) begin
      resp_valid[p] = resp[p].valid;
      resp_err[p]   = resp[p].err;
      resp_data[p]  = resp[p].data[DATA_WIDTH-1:0];
    end
  end

  a_one_grant: assert property (
    @(posedge clock) disable iff (!reset_n) $onehot0(req_ready));

  a_ptr_range: assert property (
    @(posedge clock) disable iff (!reset_n) (32'(rr_ptr) < 32'(PORTS)));

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: arbitration order, read/write
// responses, range errors, read-after-write and reset behaviour.
module tb_mem_responder;

  logic         clock;
  logic         reset_n;
  logic [7:0]   req_valid;
  logic [7:0]   req_write;
  logic [15:0]  req_addr [8];
  logic [511:0] req_wdata [8];
  logic [7:0]   req_ready;
  logic [7:0]   resp_valid;
  logic [511:0] resp_data [8];
  logic [7:0]   resp_err;

  int checks = 0;
  int errors = 0;

  logic [511:0] a5;
  logic [511:0] d0;
  logic [511:0] ones;

  mem_responder dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_write = '0;
    for (int p = 0; p < 8; p++) begin
      req_addr[p]  = '0;
      req_wdata[p] = '0;
    end
  endtask

  task automatic drive(input int p, input bit wr,
                       input logic [15:0] a, input logic [511:0] d);
    req_valid[p] = 1'b1;
    req_write[p] = wr;
    req_addr[p]  = a;
    req_wdata[p] = d;
  endtask

  task automatic test_reset();
    logic any_data;
    reset_n = 1'b0;
    clear_reqs();
    for (int p = 0; p < 8; p++) drive(p, 1'b0, 16'd0, '0);
    @(negedge clock);
    checks++;
    if (req_ready !== 8'h00) begin
      errors++;
      $display("FAIL reset_ready got %h want 00", req_ready);
    end
    checks++;
    if (resp_valid !== 8'h00) begin
      errors++;
      $display("FAIL reset_valid got %h want 00", resp_valid);
    end
    checks++;
    if (resp_err !== 8'h00) begin
      errors++;
      $display("FAIL reset_err got %h want 00", resp_err);
    end
    any_data = 1'b0;
    for (int p = 0; p < 8; p++)
      if (resp_data[p] !== '0) any_data = 1'b1;
    checks++;
    if (any_data !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got nonzero want 0");
    end
  endtask

  task automatic test_write_read();
    step();
    clear_reqs();
    reset_n = 1'b1;
    drive(3, 1'b1, 16'd7, a5);
    @(negedge clock);
    checks++;
    if (req_ready !== 8'h08) begin
      errors++;
      $display("FAIL wr_ready got %h want 08", req_ready);
    end
    step();
    drive(3, 1'b0, 16'd7, '0);
    @(negedge clock);
    checks++;
    if (resp_valid !== 8'h08 || resp_err !== 8'h00) begin
      errors++;
      $display("FAIL wr_resp got v=%h e=%h want v=08 e=00",
               resp_valid, resp_err);
    end
    checks++;
    if (resp_data[3] !== '0) begin
      errors++;
      $display("FAIL wr_data got %h want 0", resp_data[3]);
    end
    step();
    clear_reqs();
    @(negedge clock);
    checks++;
    if (resp_valid !== 8'h08 || resp_err !== 8'h00) begin
      errors++;
      $display("FAIL rd_resp got v=%h e=%h want v=08 e=00",
               resp_valid, resp_err);
    end
    checks++;
    if (resp_data[3] !== a5) begin
      errors++;
      $display("FAIL rd_data got %h want %h", resp_data[3], a5);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp;
    step();
    reset_n = 1'b0;
    clear_reqs();
    for (int p = 0; p < 8; p++) drive(p, 1'b0, 16'd0, '0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      exp = 8'd1 << (i % 8);
      checks++;
      if (req_ready !== exp) begin
        errors++;
        $display("FAIL rr_grant%0d got %h want %h", i, req_ready, exp);
      end
      if (i > 0) begin
        exp = 8'd1 << ((i - 1) % 8);
        checks++;
        if (resp_valid !== exp) begin
          errors++;
          $display("FAIL rr_resp%0d got %h want %h", i, resp_valid, exp);
        end
      end
      step();
    end
    clear_reqs();
  endtask

  task automatic test_ptr_wrap();
    logic [7:0] exp [3];
    exp[0] = 8'h04;
    exp[1] = 8'h20;
    exp[2] = 8'h04;
    drive(5, 1'b0, 16'd0, '0);
    @(negedge clock);
    checks++;
    if (req_ready !== 8'h20) begin
      errors++;
      $display("FAIL wrap_setup got %h want 20", req_ready);
    end
    step();
    drive(2, 1'b0, 16'd0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (req_ready !== exp[i]) begin
        errors++;
        $display("FAIL wrap_grant%0d got %h want %h",
                 i, req_ready, exp[i]);
      end
      step();
    end
    clear_reqs();
  endtask

  task automatic test_out_of_range();
    drive(0, 1'b1, 16'd0, d0);
    step();
    clear_reqs();
    drive(1, 1'b1, 16'd1024, ones);
    @(negedge clock);
    checks++;
    if (req_ready !== 8'h02) begin
      errors++;
      $display("FAIL oor_wr_ready got %h want 02", req_ready);
    end
    step();
    drive(1, 1'b0, 16'd1024, '0);
    @(negedge clock);
    checks++;
    if (resp_valid !== 8'h02 || resp_err !== 8'h02) begin
      errors++;
      $display("FAIL oor_wr_resp got v=%h e=%h want v=02 e=02",
               resp_valid, resp_err);
    end
    step();
    clear_reqs();
    drive(0, 1'b0, 16'd0, '0);
    @(negedge clock);
    checks++;
    if (resp_valid !== 8'h02 || resp_err !== 8'h02) begin
      errors++;
      $display("FAIL oor_rd_resp got v=%h e=%h want v=02 e=02",
               resp_valid, resp_err);
    end
    checks++;
    if (resp_data[1] !== '0) begin
      errors++;
      $display("FAIL oor_rd_data got %h want 0", resp_data[1]);
    end
    step();
    clear_reqs();
    @(negedge clock);
    checks++;
    if (resp_valid !== 8'h01 || resp_err !== 8'h00) begin
      errors++;
      $display("FAIL addr0_resp got v=%h e=%h want v=01 e=00",
               resp_valid, resp_err);
    end
    checks++;
    if (resp_data[0] !== d0) begin
      errors++;
      $display("FAIL addr0_data got %h want %h", resp_data[0], d0);
    end
  endtask

  task automatic test_back_to_back();
    step();
    drive(0, 1'b1, 16'd9, 512'd1);
    step();
    clear_reqs();
    drive(4, 1'b0, 16'd9, '0);
    @(negedge clock);
    checks++;
    if (req_ready !== 8'h10 || resp_valid !== 8'h01) begin
      errors++;
      $display("FAIL b2b_mid got r=%h v=%h want r=10 v=01",
               req_ready, resp_valid);
    end
    step();
    clear_reqs();
    @(negedge clock);
    checks++;
    if (resp_valid !== 8'h10) begin
      errors++;
      $display("FAIL b2b_valid got %h want 10", resp_valid);
    end
    checks++;
    if (resp_data[4] !== 512'd1) begin
      errors++;
      $display("FAIL b2b_data got %h want 1", resp_data[4]);
    end
  endtask

  task automatic test_reset_drop();
    step();
    drive(2, 1'b0, 16'd7, '0);
    step();
    clear_reqs();
    reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if (resp_valid !== 8'h00 || resp_data[2] !== '0) begin
      errors++;
      $display("FAIL drop_resp got v=%h want 00", resp_valid);
    end
    for (int p = 0; p < 8; p++) drive(p, 1'b0, 16'd7, '0);
    step();
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 8'h01) begin
      errors++;
      $display("FAIL drop_ptr got %h want 01", req_ready);
    end
    checks++;
    if (resp_valid !== 8'h00) begin
      errors++;
      $display("FAIL drop_late got %h want 00", resp_valid);
    end
    step();
    clear_reqs();
    @(negedge clock);
    checks++;
    if (resp_valid !== 8'h01) begin
      errors++;
      $display("FAIL drop_next got %h want 01", resp_valid);
    end
  endtask

  initial begin
    a5   = {64{8'hA5}};
    d0   = {16{32'h1234_5678}};
    ones = '1;
    reset_n = 1'b0;
    clear_reqs();
    test_reset();
    test_write_read();
    test_round_robin();
    test_ptr_wrap();
    test_out_of_range();
    test_back_to_back();
    test_reset_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter PORTS, default 8: number of requesting processing blocks.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: request address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 512: word width (32 lanes x 16 bits).
REQ-004 SHALL have parameter DEPTH, default 1024: implemented words; valid addresses are 0..DEPTH-1.
REQ-005 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port req_valid[PORTS], input, 1 each: request present.
REQ-008 SHALL have port req_write[PORTS], input, 1 each: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr[PORTS], input, ADDR_WIDTH each: word address.
REQ-010 SHALL have port req_wdata[PORTS], input, DATA_WIDTH each: write data.
REQ-011 SHALL have port req_ready[PORTS], output, 1 each: request accepted this cycle.
REQ-012 SHALL have port resp_valid[PORTS], output, 1 each: response present, one-cycle pulse.
REQ-013 SHALL have port resp_data[PORTS], output, DATA_WIDTH each: read data; 0 for writes.
REQ-014 SHALL have port resp_err[PORTS], output, 1 each: address was out of range.

Function
REQ-015 SHALL accept a request on port p when req_valid[p] && req_ready[p] at a rising clock edge.
REQ-016 SHALL assert at most one req_ready per cycle; req_ready is combinational from req_valid and the round-robin pointer.
REQ-017 SHALL grant the first valid port at or after rr_ptr, searching cyclically; no valid port -> no grant, rr_ptr unchanged.
REQ-018 SHALL set rr_ptr to (granted port + 1) mod PORTS after each grant.
REQ-019 SHALL assume initiators hold req_valid and the payload stable until req_ready; a dropped req_valid withdraws the request without any response.
REQ-020 SHALL commit an accepted in-range write to storage at the acceptance edge.
REQ-021 SHALL, for an accepted in-range read, drive resp_valid[p]=1 and resp_data[p]=stored word exactly one cycle after acceptance.
REQ-022 SHALL also pulse resp_valid[p] one cycle after an accepted write, with resp_data[p]=0.
REQ-023 SHALL treat any address >= DEPTH as out of range: write discarded, read data 0, resp_err[p]=1 with the response.
REQ-024 SHALL return a read to address X that was accepted in the cycle after a write to X with the new data.
REQ-025 SHALL hold resp_valid, resp_data and resp_err at 0 on every port that has no response in a cycle.
REQ-026 SHALL sustain one accepted request per cycle with no idle cycles while any port is valid.

Reset
REQ-027 SHALL, while reset_n=0: rr_ptr=0; all resp_valid, resp_data and resp_err=0; all req_ready=0.
REQ-028 SHALL drop, with no response after reset release, any response pending when reset asserts.
REQ-029 SHALL not reset storage contents; reads before the first write return undefined data.
REQ-030 SHALL grant port 0 first on the first cycle after release when all ports are valid.

Structure
REQ-031 SHALL take ADDR_WIDTH/DATA_WIDTH defaults and the response record typedef (valid, data, err) from shared package gpu_mem_pkg.
REQ-032 SHALL implement arbitration in one sub-module, rr_arbiter (PORTS-wide request vector in; one-hot grant and pointer state out).
REQ-033 SHALL infer storage as a single-write, single-read synchronous array.

Verification
REQ-034 SHALL pass: port 3 writes 0xA5..A5 to address 7, then reads address 7 -> resp_valid[3] one cycle after each acceptance; read returns 0xA5..A5, resp_err=0.
REQ-035 SHALL pass: all 8 ports valid continuously from reset -> grants 0,1,...,7,0 on consecutive cycles, one grant per cycle.
REQ-036 SHALL pass: only ports 2 and 5 valid with rr_ptr=6 -> grant 2, then 5, then 2.
REQ-037 SHALL pass: port 1 reads address 1024 with DEPTH=1024 -> resp_err[1]=1 and resp_data[1]=0; a write to 1024 leaves address 0 unchanged.
REQ-038 SHALL pass: port 0 writes 0x1 to address 9, and port 4 reads address 9 in the next cycle -> port 4 receives 0x1.
REQ-039 SHALL pass: reset_n pulsed low in the cycle after a read acceptance -> no resp_valid, and rr_ptr=0 after release.
